adder_sched: RTL



---
 rtl/adder_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/adder_sched.sv
`default_nettype none
// ============================================================================
//  Module   : adder_sched
//  Purpose  : Burst-level round-robin scheduler that lends one shared
//             combinational adder to NREQ requesters. A grant lasts one
//             packet (up to MAX_BURST flits). Each sum is registered with
//             its source ID, and the result port honours backpressure.
//  Options  : define ADDER_SCHED_STATS_EN to add the saturating
//             busy/transfer/total cycle counters and the stat_clear port.
//  Revision : 1.0  initial release
// ============================================================================
module adder_sched #(
    parameter int N         = 18,
    parameter int NREQ      = 4,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      add_a,
    output logic [N-1:0]      add_b,
    input  logic [N-1:0]      add_sum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [N-1:0]      res_sum,
    output logic [ID_W-1:0]   res_id,
    output logic              res_last,
    output logic              busy,
    output logic [ID_W-1:0]   gnt_id
`ifdef ADDER_SCHED_STATS_EN
    ,
    input  logic              stat_clear,
    output logic [31:0]       stat_busy_cycles,
    output logic [31:0]       stat_xfer_cnt,
    output logic [31:0]       stat_total_cycles
`endif
);

    localparam logic [7:0]    C_LAST_BEAT = 8'(MAX_BURST - 1);
    localparam logic [ID_W:0] C_NREQ      = (ID_W+1)'(NREQ);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_gnt_id;
    logic [7:0]      r_beat_cnt;
    logic            r_res_valid;
    logic [N-1:0]    r_res_sum;
    logic [ID_W-1:0] r_res_id;
    logic            r_res_last;

    logic [ID_W-1:0] w_pick;
    logic [ID_W-1:0] w_rr_nxt;
    logic            w_out_free;
    logic            w_xfer;
    logic            w_eob;

    // Per-requester operand views, so the granted slice is a simple mux.
    logic [N-1:0] w_a_arr [NREQ];
    logic [N-1:0] w_b_arr [NREQ];

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_unpack
            assign w_a_arr[g] = req_a[g*N +: N];
            assign w_b_arr[g] = req_b[g*N +: N];
        end
    endgenerate

    // Round-robin pick: scanning offsets from high to low leaves the lowest
    // valid offset from rr_ptr as the final winner.
    always_comb begin
        logic [ID_W:0] idx;
        idx    = '0;
        w_pick = r_rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
            if (idx >= C_NREQ) begin
                idx = idx - C_NREQ;
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                w_pick = idx[ID_W-1:0];
            end
        end
    end

    // Pointer advance past the current grant, wrapping at NREQ.
    always_comb begin
        logic [ID_W:0] nxt;
        nxt = {1'b0, r_gnt_id} + (ID_W+1)'(1);
        if (nxt >= C_NREQ) begin
            nxt = '0;
        end
        w_rr_nxt = nxt[ID_W-1:0];
    end

    // No flit may be accepted while reset is asserted.
    assign w_out_free = !r_res_valid || res_ready;
    assign w_xfer     = (r_state == S_BURST) && req_valid[r_gnt_id] && w_out_free && !rst;
    assign w_eob      = req_last[r_gnt_id] || (r_beat_cnt == C_LAST_BEAT);

    // Next state, ready steering and operand isolation outside of a burst.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        add_a       = '0;
        add_b       = '0;
        if (r_state == S_BURST) begin
            req_ready[r_gnt_id] = w_out_free && !rst;
            add_a               = w_a_arr[r_gnt_id];
            add_b               = w_b_arr[r_gnt_id];
            if (w_xfer && w_eob) begin
                w_state_nxt = S_IDLE;
            end
        end else if (|req_valid) begin
            w_state_nxt = S_BURST;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, beat counter, round-robin pointer and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_gnt_id    <= '0;
            r_beat_cnt  <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_res_last  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_beat_cnt <= '0;
                if (|req_valid) begin
                    r_gnt_id <= w_pick;
                end
            end
            if (w_xfer) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= add_sum;
                r_res_id    <= r_gnt_id;
                r_res_last  <= w_eob;
                r_beat_cnt  <= r_beat_cnt + 8'd1;
                if (w_eob) begin
                    r_rr_ptr <= w_rr_nxt;
                end
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;
    assign res_last  = r_res_last;
    assign busy      = (r_state == S_BURST);
    assign gnt_id    = r_gnt_id;

`ifdef ADDER_SCHED_STATS_EN
    logic [31:0] r_stat_busy;
    logic [31:0] r_stat_xfer;
    logic [31:0] r_stat_total;

    // Saturating activity counters, cleared by reset or stat_clear.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_stat_busy  <= '0;
            r_stat_xfer  <= '0;
            r_stat_total <= '0;
        end else begin
            if (r_stat_total != '1) begin
                r_stat_total <= r_stat_total + 32'd1;
            end
            if ((r_state == S_BURST) && (r_stat_busy != '1)) begin
                r_stat_busy <= r_stat_busy + 32'd1;
            end
            if (w_xfer && (r_stat_xfer != '1)) begin
                r_stat_xfer <= r_stat_xfer + 32'd1;
            end
        end
    end

    assign stat_busy_cycles  = r_stat_busy;
    assign stat_xfer_cnt     = r_stat_xfer;
    assign stat_total_cycles = r_stat_total;
`endif

endmodule
`default_nettype wire
